bin_to_seg7_multi: RTL and testbench
====================================

// Module: bin_to_seg7_multi
// PURPOSE
//   Multi-channel binary-to-decimal seven-segment driver. It converts CH unsigned WIDTH-bit values
//   (e.g. cursor X/Y) to DIGITS decimal digits each and drives HEX-style segment outputs.
//   A single shared serial double-dabble core converts the channels round-robin.
//   Adds leading-zero blanking, overflow indication and a frame-done strobe.
// PARAMETERS
//   CH              2   number of channels (>=1)
//   WIDTH           8   bits per input value (1..32)
//   DIGITS          3   displayed decimal digits per channel (>=1)
//   SEG_ACTIVE_LOW  1   1: segment on = 0 (DE-series HEX); 0: segment on = 1
// PORTS
//   CLK       in   1               system clock
//   NRST      in   1               asynchronous active-low reset
//   en        in   1               1: convert continuously; 0: stop after the current frame
//   blank_lz  in   1               1: blank leading zeros
//   val       in   CH*WIDTH        channel c = val[c*WIDTH +: WIDTH]
//   seg       out  CH*DIGITS*7     channel c, digit d (d=0 is units) = seg[(c*DIGITS+d)*7 +: 7]; bit6=g .. bit0=a
//   ovf       out  CH              per channel: value >= 10**DIGITS
//   frame_done out 1               1-cycle pulse when the last channel commits
// BEHAVIOUR
//   Reset: clocking is one clock, CLK; NRST is asynchronous and active-low.
//     - While NRST is low: state=IDLE, ch=0, all seg = blank pattern (7'h7F if active low), ovf=0, frame_done=0.
//     - Reset asserted mid-frame aborts immediately and discards the partial conversion.
//     - After release, conversion restarts at channel 0.
//   FSM: IDLE -> LOAD -> SHIFT -> COMMIT -> (LOAD | IDLE)
//     - IDLE: if en=1, go to LOAD.
//     - LOAD (1 cycle): capture val slice ch into the shift register; clear the BCD register.
//       Internal BCD digit count is BDIG = (WIDTH*1233)/4096 + 1.
//     - SHIFT (WIDTH cycles): on each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1.
//     - COMMIT (1 cycle): write seg/ovf of channel ch only; other channels hold their values.
//       * If ch==CH-1: pulse frame_done, set ch=0, go to LOAD if en=1, else IDLE.
//       * Otherwise: ch+1, go to LOAD.
//   Latency: WIDTH+2 cycles per channel; a frame is CH*(WIDTH+2) cycles, with no gap while en=1.
//   Input sampling: val is sampled only in LOAD. Changes during SHIFT/COMMIT do not affect that result.
//     blank_lz is sampled at COMMIT.
//   en low mid-frame: the frame completes (all channels commit), then the FSM goes to IDLE.
//   Overflow: ovf[c]=1 when any BCD nibble at index >= DIGITS is nonzero. All DIGITS digits of channel c
//     then show dash (segment g only), regardless of blank_lz.
//   Leading-zero blanking: digit d>0 is blank when blank_lz=1 and digits d..DIGITS-1 are all 0.
//     The units digit is never blanked, so value 0 shows "0".
//   Encoding (active high, g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=27 8=7F 9=6F dash=40 blank=00.
//     With SEG_ACTIVE_LOW=1, every pattern is inverted.
//   seg and ovf are registered; there is no combinational path from inputs to outputs.
// STRUCTURE
//   seg7_pkg:
//     - digit/dash/blank pattern constants
//     - function seg7_enc(nibble, active_low)
//     - function bcd_digits(width)
//     - FSM state enum
//   Sub-module bin2bcd_serial #(WIDTH):
//     - ports: CLK, NRST, start, bin, busy, done, bcd[4*BDIG-1:0]
//     - owns the LOAD/SHIFT sequencing; done is a 1-cycle pulse
//   Top level holds the channel counter, the COMMIT logic, the output registers and blanking/overflow decode.
// TESTING (CH=2, WIDTH=8, DIGITS=3, SEG_ACTIVE_LOW=1 unless noted)
//   1. NRST low for 3 cycles -> every seg nibble-group = 7'h7F, ovf=2'b00, frame_done=0.
//   2. val={8'd0,8'd255}, blank_lz=0, en=1 -> frame_done exactly 20 cycles after the first LOAD;
//      ch0 digits (d2,d1,d0)=(24,12,12); ch1 (40,40,40).
//   3. ch0=7, blank_lz=1 -> ch0 (7F,7F,58); ch0=0 -> (7F,7F,40); ch0=105 -> (79,40,12).
//   4. DIGITS=2 instance, ch0=100 -> ovf[0]=1, ch0 (3F,3F); ch0=99 -> ovf[0]=0, (10,10).
//   5. ch0=42 at LOAD, then changed to 99 on the 3rd SHIFT cycle -> commit shows 042 (40,19,24);
//      next frame shows 099.
//   6. NRST pulsed low during ch1 SHIFT -> seg immediately 7F, no frame_done.
//      After release, ch0 commits first, at cycle WIDTH+2.
//   7. en dropped during ch0 SHIFT -> ch1 still commits, frame_done pulses once, FSM stays IDLE.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multi-channel binary-to-seven-segment driver:
// segment patterns, encoder, BCD digit-count helper and the control FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Nibble codes outside 0..9 select the non-numeric glyphs.
  localparam logic [3:0] NIB_DASH  = 4'hA;
  localparam logic [3:0] NIB_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  function automatic logic [6:0] seg7_enc(input logic [3:0] nibble, input logic active_low);
    logic [6:0] pat;
    case (nibble)
      4'd0:     pat = 7'h3F;
      4'd1:     pat = 7'h06;
      4'd2:     pat = 7'h5B;
      4'd3:     pat = 7'h4F;
      4'd4:     pat = 7'h66;
      4'd5:     pat = 7'h6D;
      4'd6:     pat = 7'h7D;
      4'd7:     pat = 7'h27;
      4'd8:     pat = 7'h7F;
      4'd9:     pat = 7'h6F;
      NIB_DASH: pat = SEG_DASH;
      default:  pat = SEG_BLANK;
    endcase
    return active_low ? ~pat : pat;
  endfunction

  // 1233/4096 approximates log10(2), giving the decimal digits of 2**width-1.
  function automatic int bcd_digits(input int width);
    return (width * 1233) / 4096 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one LOAD cycle on start, then WIDTH shift cycles.
// done is high during the final shift cycle; bcd holds the result from the next cycle on.
module bin2bcd_serial
  import seg7_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BDIG  = bcd_digits(WIDTH)
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              start,
  input  logic [WIDTH-1:0]  bin,
  output logic              busy,
  output logic              done,
  output logic [4*BDIG-1:0] bcd
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [4*BDIG-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]  cnt_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_d, bin_d} = {adj, bin_q} << 1;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      bin_q <= bin;
      bcd_q <= '0;
      cnt_q <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CNT_W'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/bin_to_seg7_multi.sv
// Multi-channel binary-to-decimal seven-segment driver sharing one serial BCD core
// round-robin across channels, with leading-zero blanking and overflow dashes.
module bin_to_seg7_multi
  import seg7_pkg::*;
#(
  parameter int CH             = 2,
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                   CLK,
  input  logic                   NRST,
  input  logic                   en,
  input  logic                   blank_lz,
  input  logic [CH*WIDTH-1:0]    val,
  output logic [CH*DIGITS*7-1:0] seg,
  output logic [CH-1:0]          ovf,
  output logic                   frame_done
);

  localparam int BDIG = bcd_digits(WIDTH);
  localparam int NDIG = (BDIG > DIGITS) ? BDIG : DIGITS;
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CH_W-1:0] CH_LAST   = CH_W'(CH - 1);
  localparam logic [6:0]      BLANK_PAT = seg7_enc(NIB_BLANK, SEG_ACTIVE_LOW);

  state_e                 state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [CH*DIGITS*7-1:0] seg_q;
  logic [CH-1:0]          ovf_q;
  logic                   frame_done_q;

  logic                   core_start, core_busy, core_done;
  logic [WIDTH-1:0]       core_bin;
  logic [4*BDIG-1:0]      core_bcd;
  logic                   last_ch;

  logic [4*NDIG-1:0]      bcd_ext;
  logic [DIGITS*7-1:0]    seg_new;
  logic                   ovf_new;
  logic                   all_zero;
  logic [3:0]             code;

  assign last_ch    = (ch_q == CH_LAST);
  assign core_start = (state_q == ST_LOAD);
  assign core_bin   = val[int'(ch_q)*WIDTH +: WIDTH];

  bin2bcd_serial #(
    .WIDTH (WIDTH),
    .BDIG  (BDIG)
  ) u_core (
    .CLK   (CLK),
    .NRST  (NRST),
    .start (core_start),
    .bin   (core_bin),
    .busy  (core_busy),
    .done  (core_done),
    .bcd   (core_bcd)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (core_done || !core_busy) state_d = ST_COMMIT;
      ST_COMMIT: begin
        if (last_ch) begin
          ch_d    = '0;
          state_d = en ? ST_LOAD : ST_IDLE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Decode the finished BCD word; scan digits from the top so blanking sees all higher zeros.
  always_comb begin
    bcd_ext               = '0;
    bcd_ext[4*BDIG-1:0]   = core_bcd;
    ovf_new               = 1'b0;
    all_zero              = 1'b1;
    code                  = NIB_BLANK;
    seg_new               = '0;
    for (int i = DIGITS; i < NDIG; i++) begin
      if (bcd_ext[4*i +: 4] != 4'd0) ovf_new = 1'b1;
    end
    for (int d = DIGITS - 1; d >= 0; d--) begin
      all_zero = all_zero && (bcd_ext[4*d +: 4] == 4'd0);
      if (ovf_new)                          code = NIB_DASH;
      else if (d > 0 && blank_lz && all_zero) code = NIB_BLANK;
      else                                  code = bcd_ext[4*d +: 4];
      seg_new[7*d +: 7] = seg7_enc(code, SEG_ACTIVE_LOW);
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      seg_q        <= {CH*DIGITS{BLANK_PAT}};
      ovf_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      frame_done_q <= (state_q == ST_COMMIT) && last_ch;
      if (state_q == ST_COMMIT) begin
        for (int c = 0; c < CH; c++) begin
          if (ch_q == CH_W'(c)) begin
            seg_q[c*DIGITS*7 +: DIGITS*7] <= seg_new;
            ovf_q[c]                      <= ovf_new;
          end
        end
      end
    end
  end

  assign seg        = seg_q;
  assign ovf        = ovf_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bin_to_seg7_multi.sv
// Self-checking bench for bin_to_seg7_multi (CH=2, WIDTH=8; DIGITS=3 and DIGITS=2 instances).
module tb_bin_to_seg7_multi;

  logic        CLK      = 1'b0;
  logic        NRST     = 1'b1;
  logic        en       = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] val      = '0;
  logic [15:0] val2     = '0;
  logic [41:0] seg;
  logic [1:0]  ovf;
  logic        frame_done;
  logic [27:0] seg2;
  logic [1:0]  ovf2;
  logic        frame_done2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [41:0] seg;
    logic [1:0]  ovf;
  } exp_t;
  exp_t sbq[$];

  always #5 CLK = ~CLK;

  bin_to_seg7_multi #(.CH(2), .WIDTH(8), .DIGITS(3), .SEG_ACTIVE_LOW(1'b1)) dut (
    .CLK(CLK), .NRST(NRST), .en(en), .blank_lz(blank_lz), .val(val),
    .seg(seg), .ovf(ovf), .frame_done(frame_done)
  );

  bin_to_seg7_multi #(.CH(2), .WIDTH(8), .DIGITS(2), .SEG_ACTIVE_LOW(1'b1)) dut2 (
    .CLK(CLK), .NRST(NRST), .en(en), .blank_lz(blank_lz), .val(val2),
    .seg(seg2), .ovf(ovf2), .frame_done(frame_done2)
  );

  // Active-low glyph for a decimal digit; 10 = dash, anything else = blank.
  function automatic logic [6:0] pat(input int code);
    logic [6:0] p;
    case (code)
      0: p = 7'h3F;  1: p = 7'h06;  2: p = 7'h5B;  3: p = 7'h4F;
      4: p = 7'h66;  5: p = 7'h6D;  6: p = 7'h7D;  7: p = 7'h27;
      8: p = 7'h7F;  9: p = 7'h6F;  10: p = 7'h40;
      default: p = 7'h00;
    endcase
    return ~p;
  endfunction

  function automatic logic [20:0] model_ch(input int v, input logic blz);
    int dg[3];
    logic lead;
    logic [20:0] r;
    dg[0] = v % 10;
    dg[1] = (v / 10) % 10;
    dg[2] = (v / 100) % 10;
    lead  = 1'b1;
    r     = '0;
    for (int d = 2; d >= 0; d--) begin
      if (dg[d] != 0) lead = 1'b0;
      if (d > 0 && blz && lead) r[7*d +: 7] = pat(11);
      else                      r[7*d +: 7] = pat(dg[d]);
    end
    return r;
  endfunction

  task automatic push_exp(input int c0, input int c1, input logic blz);
    exp_t e;
    e.seg = {model_ch(c1, blz), model_ch(c0, blz)};
    e.ovf = 2'b00;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_frames(input int n, input bit second, output bit ok);
    int seen = 0;
    ok = 1'b0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      tick();
      if (second ? frame_done2 : frame_done) seen++;
    end
    ok = (seen == n);
  endtask

  task automatic test_reset();
    en = 1'b0; val = '0; val2 = '0;
    #2 NRST = 1'b0;
    repeat (3) tick();
    checks++; if (seg !== {6{7'h7F}}) begin errors++; $display("FAIL reset_seg: got %h want %h", seg, {6{7'h7F}}); end
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b want 00", ovf); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    checks++; if (seg2 !== {4{7'h7F}}) begin errors++; $display("FAIL reset_seg2: got %h want %h", seg2, {4{7'h7F}}); end
  endtask

  task automatic test_basic();
    exp_t e;
    int fd_at = -1;
    val = {8'd0, 8'd255}; blank_lz = 1'b0; en = 1'b1;
    push_exp(255, 0, 1'b0);
    tick();
    NRST = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (frame_done) begin fd_at = n; break; end
    end
    checks++; if (fd_at != 21) begin errors++; $display("FAIL basic_latency: frame_done at edge %0d want 21", fd_at); end
    e = sbq.pop_front();
    checks++; if (seg !== e.seg) begin errors++; $display("FAIL basic_seg: got %h want %h", seg, e.seg); end
    checks++; if (ovf !== e.ovf) begin errors++; $display("FAIL basic_ovf: got %b want %b", ovf, e.ovf); end
    checks++; if (seg[20:0] !== {7'h24, 7'h12, 7'h12}) begin errors++; $display("FAIL basic_ch0: got %h want 24/12/12", seg[20:0]); end
    checks++; if (seg[41:21] !== {3{7'h40}}) begin errors++; $display("FAIL basic_ch1: got %h want 40/40/40", seg[41:21]); end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_pulse: frame_done %b want 0", frame_done); end
  endtask

  task automatic test_blanking();
    logic [7:0]  v0 [3]  = '{8'd7, 8'd0, 8'd105};
    logic [20:0] lit [3] = '{{7'h7F, 7'h7F, 7'h58}, {7'h7F, 7'h7F, 7'h40}, {7'h79, 7'h40, 7'h12}};
    exp_t e;
    bit ok;
    blank_lz = 1'b1;
    for (int i = 0; i < 3; i++) begin
      val = {8'(200 + i), v0[i]};
      push_exp(int'(v0[i]), 200 + i, 1'b1);
      wait_frames(2, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL blank_timeout: case %0d no frame_done", i); end
      e = sbq.pop_front();
      checks++; if (seg !== e.seg) begin errors++; $display("FAIL blank_seg: case %0d got %h want %h", i, seg, e.seg); end
      checks++; if (seg[20:0] !== lit[i]) begin errors++; $display("FAIL blank_lit: case %0d got %h want %h", i, seg[20:0], lit[i]); end
    end
  endtask

  task automatic test_random();
    exp_t e;
    bit ok;
    logic [15:0] r;
    logic b;
    for (int i = 0; i < 6; i++) begin
      r = 16'($urandom);
      b = 1'($urandom_range(0, 1));
      val = r; blank_lz = b;
      push_exp(int'(r[7:0]), int'(r[15:8]), b);
      wait_frames(2, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_timeout: iter %0d", i); end
      e = sbq.pop_front();
      checks++; if (seg !== e.seg) begin errors++; $display("FAIL rand_seg: val %h blz %b got %h want %h", r, b, seg, e.seg); end
      checks++; if (ovf !== e.ovf) begin errors++; $display("FAIL rand_ovf: got %b want %b", ovf, e.ovf); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    blank_lz = 1'b0;
    val2 = {8'd255, 8'd100};
    wait_frames(2, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: no frame_done2"); end
    checks++; if (ovf2 !== 2'b11) begin errors++; $display("FAIL ovf_flag: got %b want 11", ovf2); end
    checks++; if (seg2 !== {4{7'h3F}}) begin errors++; $display("FAIL ovf_dash: got %h want %h", seg2, {4{7'h3F}}); end
    val2 = {8'd9, 8'd99};
    wait_frames(2, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout2: no frame_done2"); end
    checks++; if (ovf2 !== 2'b00) begin errors++; $display("FAIL ovf_clear: got %b want 00", ovf2); end
    checks++; if (seg2 !== {7'h40, 7'h10, 7'h10, 7'h10}) begin errors++; $display("FAIL ovf_99: got %h want 40101010", seg2); end
  endtask

  task automatic test_sample_hold();
    bit ok;
    #1 NRST = 1'b0;
    val = {8'd5, 8'd42}; blank_lz = 1'b0; en = 1'b1;
    tick(); tick();
    NRST = 1'b1;
    repeat (4) tick();
    val[7:0] = 8'd99;
    wait_frames(1, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_timeout: first frame"); end
    checks++; if (seg[20:0] !== {7'h40, 7'h19, 7'h24}) begin errors++; $display("FAIL hold_042: got %h want 40/19/24", seg[20:0]); end
    wait_frames(1, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_timeout2: second frame"); end
    checks++; if (seg[20:0] !== {7'h40, 7'h10, 7'h10}) begin errors++; $display("FAIL hold_099: got %h want 40/10/10", seg[20:0]); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int fd_at = -1;
    int fd_in_rst = 0;
    blank_lz = 1'b0;
    wait_frames(1, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout: no frame"); end
    repeat (13) tick();
    val = {8'd45, 8'd123};
    NRST = 1'b0;
    #1;
    checks++; if (seg !== {6{7'h7F}}) begin errors++; $display("FAIL midrst_seg: got %h want all 7F", seg); end
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL midrst_ovf: got %b want 00", ovf); end
    repeat (2) begin tick(); if (frame_done) fd_in_rst++; end
    checks++; if (fd_in_rst != 0) begin errors++; $display("FAIL midrst_fd: %0d pulses in reset want 0", fd_in_rst); end
    NRST = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 10) begin
        checks++; if (seg !== {6{7'h7F}}) begin errors++; $display("FAIL midrst_early: got %h want all 7F", seg); end
      end
      if (n == 11) begin
        checks++; if (seg[20:0] !== model_ch(123, 1'b0)) begin errors++; $display("FAIL midrst_ch0: got %h want %h", seg[20:0], model_ch(123, 1'b0)); end
        checks++; if (seg[41:21] !== {3{7'h7F}}) begin errors++; $display("FAIL midrst_ch1: got %h want blank", seg[41:21]); end
      end
      if (frame_done && fd_at < 0) fd_at = n;
    end
    checks++; if (fd_at != 21) begin errors++; $display("FAIL midrst_frame: frame_done at %0d want 21", fd_at); end
  endtask

  task automatic test_en_drop();
    int pulses = 0;
    logic [41:0] want;
    #1 NRST = 1'b0;
    val = {8'd77, 8'd66}; blank_lz = 1'b0; en = 1'b1;
    want = {model_ch(77, 1'b0), model_ch(66, 1'b0)};
    tick(); tick();
    NRST = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (frame_done) begin
        pulses++;
        checks++; if (seg !== want) begin errors++; $display("FAIL endrop_seg: got %h want %h", seg, want); end
      end
      if (n == 40) val = {8'd1, 8'd2};
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL endrop_pulses: got %0d want 1", pulses); end
    checks++; if (seg !== want) begin errors++; $display("FAIL endrop_idle: got %h want %h", seg, want); end
    en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_blanking();
    test_random();
    test_overflow();
    test_sample_hold();
    test_reset_midframe();
    test_en_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
